ram_bank: RTL

//  Parametrised data RAM for the core's load/store path: one write port with

---
 rtl/ram_bank.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ram_bank.sv
// ----------------------------------------------------------------------------
// ram_bank
//   Data RAM for the load/store path. One write port with byte strobes and
//   one read port with a req/gnt/valid handshake and a fixed read latency of
//   RD_LAT cycles. Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH words) are
//   flagged instead of aliasing onto a real word.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   we_i       write request, single cycle, always accepted
//   waddr_i    write byte address
//   wdata_i    write data
//   wstrb_i    byte-lane enables; bit n covers wdata_i[8n+7:8n]
//   wr_err_o   one-cycle pulse: the previous-cycle write was out of range
//   rd_req_i   read request, held by the requester until rd_gnt_o is seen
//   raddr_i    read byte address, sampled on accept
//   rd_gnt_o   read port can accept this cycle
//   rd_valid_o rd_data_o / rd_err_o valid, one cycle per read
//   rd_data_o  read data; holds its last value between reads
//   rd_err_o   read was out of range; qualified by rd_valid_o
// ----------------------------------------------------------------------------
module ram_bank #(
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 256,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  wr_err_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    // RD_LAT is at most 4, so three bits always hold the countdown.
    localparam int CNT_W  = 3;

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode. The subtraction wraps for addresses below the base,
    // so the explicit "< BASE_ADDR" test is what catches those.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_off, r_off;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              w_oor, r_oor;

    assign w_off = waddr_i - BASE_ADDR;
    assign r_off = raddr_i - BASE_ADDR;
    assign w_idx = w_off[OFF_W +: IDX_W];
    assign r_idx = r_off[OFF_W +: IDX_W];
    assign w_oor = (waddr_i < BASE_ADDR) || ((w_off >> OFF_W) >= ADDR_W'(DEPTH));
    assign r_oor = (raddr_i < BASE_ADDR) || ((r_off >> OFF_W) >= ADDR_W'(DEPTH));

    logic w_hit;
    assign w_hit = we_i && !w_oor;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch; contents are undefined after
    // power-up and survive rst_n, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && w_hit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word with same-cycle write forwarding: strobed lanes of a write
    // to the same index override the stored (old) bytes.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_word;

    // NOTE: rd_word gets its default before any conditional override, so
    // every path assigns it and no latch is inferred.
    always_comb begin
        rd_word = mem[r_idx];
        if (w_hit && (w_idx == r_idx)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    rd_word[8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
        if (r_oor) begin
            rd_word = '0;
        end
    end

    // ------------------------------------------------------------------
    // Read handshake. cnt counts down from RD_LAT after an accept; the
    // result is presented when it reaches 1, which is also the first cycle
    // a new request may be accepted (back-to-back reads).
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign rd_gnt_o   = (cnt <= CNT_W'(1));
    assign rd_valid_o = (cnt == CNT_W'(1));
    assign accept     = rd_req_i && rd_gnt_o;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rd_data_o <= '0;
            rd_err_o  <= 1'b0;
            wr_err_o  <= 1'b0;
        end else begin
            wr_err_o <= we_i && w_oor;
            if (accept) begin
                cnt       <= CNT_W'(RD_LAT);
                rd_data_o <= rd_word;
                rd_err_o  <= r_oor;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
